axi_channel_join_slice: RTL

- Inverse of the channel split slice: N independent AXI-stream-style source channels are synchronised into one destination channel.
- A destination beat is formed only when every source presents a beat; the beat payload is the concatenation of all source payloads.
- The join is followed by a selectable register stage, so joins can be placed on timing-critical paths at full throughput.
- Used wherever parallel pipeline lanes reconverge before a shared consumer.

---
 rtl/axi_channel_join_slice.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axi_channel_join_slice.sv
// Joins N_INPUTS valid/ready source channels into one concatenated destination beat,
// followed by a REG_MODE-selectable register stage. Define AXI_JOIN_SLICE_STALL_CNT_EN for the stall_cnt port.
module axi_channel_join_slice #(
    parameter int N_INPUTS    = 2,
    parameter int PAYLD_WIDTH = 8,
    parameter int REG_MODE    = 2
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [N_INPUTS-1:0]             valid_src,
    input  logic [N_INPUTS*PAYLD_WIDTH-1:0] payload_src,
    output logic [N_INPUTS-1:0]             ready_src,
    output logic                            valid_dst,
    output logic [N_INPUTS*PAYLD_WIDTH-1:0] payload_dst,
    input  logic                            ready_dst
`ifdef AXI_JOIN_SLICE_STALL_CNT_EN
    ,
    output logic [15:0]                     stall_cnt
`endif
);

    localparam int DW = N_INPUTS * PAYLD_WIDTH;

    logic all_valid;
    logic stage_ready;

    assign all_valid = &valid_src;

    // A lane's ready looks only at the other lanes, so every lane handshakes together or none does.
    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_ready
            assign ready_src[gi] = stage_ready & (&(valid_src | (N_INPUTS'(1) << gi)));
        end
    endgenerate

    generate
        if (REG_MODE == 0) begin : g_bypass
            assign valid_dst   = all_valid;
            assign payload_dst = payload_src;
            assign stage_ready = ready_dst;
        end else if (REG_MODE == 1) begin : g_fwd
            logic          main_valid_q, main_valid_d;
            logic [DW-1:0] main_data_q, main_data_d;

            assign stage_ready = ready_dst | ~main_valid_q;

            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                if (stage_ready) begin
                    main_valid_d = all_valid;
                    if (all_valid) main_data_d = payload_src;
                end
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    main_valid_q <= 1'b0;
                    main_data_q  <= '0;
                end else begin
                    main_valid_q <= main_valid_d;
                    main_data_q  <= main_data_d;
                end
            end

            assign valid_dst   = main_valid_q;
            assign payload_dst = main_data_q;
        end else begin : g_full
            logic          main_valid_q, main_valid_d;
            logic [DW-1:0] main_data_q, main_data_d;
            logic          skid_full_q, skid_full_d;
            logic [DW-1:0] skid_data_q, skid_data_d;
            logic          stage_ready_q, stage_ready_d;
            logic          drain, join_fire;

            assign drain       = main_valid_q & ready_dst;
            assign join_fire   = all_valid & stage_ready_q;
            assign stage_ready = stage_ready_q;

            // A join and a skid refill never coincide: stage_ready_q is low whenever the skid is full.
            always_comb begin
                main_valid_d = main_valid_q;
                main_data_d  = main_data_q;
                skid_full_d  = skid_full_q;
                skid_data_d  = skid_data_q;
                if (drain) begin
                    if (skid_full_q) begin
                        main_data_d = skid_data_q;
                        skid_full_d = 1'b0;
                    end else begin
                        main_valid_d = join_fire;
                        if (join_fire) main_data_d = payload_src;
                    end
                end else if (join_fire) begin
                    if (!main_valid_q) begin
                        main_valid_d = 1'b1;
                        main_data_d  = payload_src;
                    end else begin
                        skid_full_d = 1'b1;
                        skid_data_d = payload_src;
                    end
                end
                stage_ready_d = ~skid_full_d;
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    main_valid_q  <= 1'b0;
                    main_data_q   <= '0;
                    skid_full_q   <= 1'b0;
                    skid_data_q   <= '0;
                    stage_ready_q <= 1'b0;
                end else begin
                    main_valid_q  <= main_valid_d;
                    main_data_q   <= main_data_d;
                    skid_full_q   <= skid_full_d;
                    skid_data_q   <= skid_data_d;
                    stage_ready_q <= stage_ready_d;
                end
            end

            assign valid_dst   = main_valid_q;
            assign payload_dst = main_data_q;
        end
    endgenerate

`ifdef AXI_JOIN_SLICE_STALL_CNT_EN
    // Counts lane-skew cycles only; destination backpressure is not a stall here.
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        lane_skew;

    assign lane_skew = (|valid_src) & ~all_valid;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (lane_skew && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
